// File: rtl/leaderboard_pkg.sv
// -----------------------------------------------------------------------------
// leaderboard_pkg
// Shared types and constants for the top-three high-score tracker.
//   lb_state_t      : insertion FSM states (IDLE, CMP, INSERT, DONE)
//   LB_DEPTH        : number of board entries
//   RANK_NONE       : rank value reported when a score is not placed
//   DEFAULT_SCORE_W : default width of scores and board entries
// -----------------------------------------------------------------------------
package leaderboard_pkg;

    localparam int          DEFAULT_SCORE_W = 8;
    localparam int          LB_DEPTH        = 3;
    localparam logic [1:0]  RANK_NONE       = 2'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP    = 2'd1,
        INSERT = 2'd2,
        DONE   = 2'd3
    } lb_state_t;

endpackage : leaderboard_pkg

// File: rtl/leaderboard_tracker_if.sv
// -----------------------------------------------------------------------------
// leaderboard_tracker_if
// Request/response bundle between the scoring stage and the leaderboard.
//   score_in    : final round score, valid with game_over
//   game_over   : single-cycle submit request
//   clear_board : request to zero the board
//   lb1..lb3    : board entries, lb1 highest
//   busy        : insertion in progress, requests ignored
//   done        : one-cycle completion pulse
//   rank        : placement of the last submission (0 = not placed)
// Modports: master = requester / display side, slave = leaderboard_tracker.
// -----------------------------------------------------------------------------
interface leaderboard_tracker_if #(
    parameter int SCORE_W = leaderboard_pkg::DEFAULT_SCORE_W
);
    logic [SCORE_W-1:0] score_in;
    logic               game_over;
    logic               clear_board;
    logic [SCORE_W-1:0] lb1;
    logic [SCORE_W-1:0] lb2;
    logic [SCORE_W-1:0] lb3;
    logic               busy;
    logic               done;
    logic [1:0]         rank;

    modport master (
        output score_in, game_over, clear_board,
        input  lb1, lb2, lb3, busy, done, rank
    );

    modport slave (
        input  score_in, game_over, clear_board,
        output lb1, lb2, lb3, busy, done, rank
    );

endinterface : leaderboard_tracker_if

// File: rtl/leaderboard_tracker.sv
// -----------------------------------------------------------------------------
// leaderboard_tracker
// Keeps a sorted three-entry high-score board. A submitted score walks the
// board from the top (CMP), is shifted in at the first entry it strictly
// beats (INSERT), and the result is reported with a done pulse and rank.
// Equal scores rank below the earlier holder.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : leaderboard_tracker_if.slave (score_in, game_over, clear_board,
//           lb1..lb3, busy, done, rank)
//
// Build option:
//   LB_DEDUP_EN : when defined, a score equal to an existing entry is not
//                 placed (rank 0, board unchanged), so no duplicates appear.
// -----------------------------------------------------------------------------
module leaderboard_tracker
    import leaderboard_pkg::*;
#(
    parameter int SCORE_W = DEFAULT_SCORE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    leaderboard_tracker_if.slave  bus
);

    lb_state_t          state_q;
    logic [1:0]         idx_q;
    logic [SCORE_W-1:0] cand_q;
    logic [SCORE_W-1:0] board_q [LB_DEPTH];
    logic [1:0]         rank_q;
    logic               busy_q;
    logic               done_q;
`ifdef LB_DEDUP_EN
    // Set when CMP found an equal entry; INSERT then becomes a no-op cycle
    // so the abort keeps the same idx+3 latency as a real placement path.
    logic               skip_q;
`endif

    // Board entries are registered outputs straight from the array.
    assign bus.lb1  = board_q[0];
    assign bus.lb2  = board_q[1];
    assign bus.lb3  = board_q[2];
    assign bus.rank = rank_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // NOTE: every register here, including the board array, is cleared by the
    // async reset; the board is visible state and must read zero immediately,
    // so it cannot be left as an unreset memory.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cand_q  <= '0;
            for (int i = 0; i < LB_DEPTH; i++) begin
                board_q[i] <= '0;
            end
            rank_q  <= RANK_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LB_DEDUP_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments only; the INSERT shift reads the
            // old entries on the right-hand side, which is what makes the
            // three-way shift correct in a single edge.
            done_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (done_q) begin
                        // The done cycle still counts as busy: requests are
                        // dropped and busy falls at the end of it.
                        busy_q <= 1'b0;
                    end else if (bus.clear_board) begin
                        for (int i = 0; i < LB_DEPTH; i++) begin
                            board_q[i] <= '0;
                        end
                    end else if (bus.game_over) begin
                        cand_q  <= bus.score_in;
                        idx_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= CMP;
                    end
                end

                CMP: begin
`ifdef LB_DEDUP_EN
                    if (cand_q == board_q[idx_q]) begin
                        skip_q  <= 1'b1;
                        state_q <= INSERT;
                    end else
`endif
                    if (cand_q > board_q[idx_q]) begin
                        state_q <= INSERT;
                    end else if (idx_q == 2'd2) begin
                        rank_q  <= RANK_NONE;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end

                INSERT: begin
`ifdef LB_DEDUP_EN
                    if (skip_q) begin
                        skip_q <= 1'b0;
                        rank_q <= RANK_NONE;
                    end else
`endif
                    begin
                        unique case (idx_q)
                            2'd0: begin
                                board_q[2] <= board_q[1];
                                board_q[1] <= board_q[0];
                                board_q[0] <= cand_q;
                            end
                            2'd1: begin
                                board_q[2] <= board_q[1];
                                board_q[1] <= cand_q;
                            end
                            default: begin
                                board_q[2] <= cand_q;
                            end
                        endcase
                        rank_q <= idx_q + 2'd1;
                    end
                    state_q <= DONE;
                end

                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : leaderboard_tracker

// File: tb/tb_leaderboard_tracker.sv
// -----------------------------------------------------------------------------
// tb_leaderboard_tracker
// Directed and random submissions against a reference board kept as a plain
// array: a score's slot is the count of entries it does not beat.
// -----------------------------------------------------------------------------
module tb_leaderboard_tracker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    leaderboard_tracker_if #(.SCORE_W(8)) bus ();

    leaderboard_tracker #(.SCORE_W(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int mb [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_board(input string tag);
        check({tag, "_lb1"}, {24'd0, bus.lb1}, mb[0]);
        check({tag, "_lb2"}, {24'd0, bus.lb2}, mb[1]);
        check({tag, "_lb3"}, {24'd0, bus.lb3}, mb[2]);
    endtask

    // Expected rank and done latency for score s on the current model board.
    task automatic predict(input int s, output int r, output int lat);
        int gt;
        int ge;
        gt = 0;
        ge = 0;
        for (int i = 0; i < 3; i++) begin
            if (mb[i] > s)  gt++;
            if (mb[i] >= s) ge++;
        end
        r   = 0;
        lat = 4;
`ifdef LB_DEDUP_EN
        if (gt < 3 && mb[gt] == s) begin
            lat = gt + 3;
            return;
        end
`endif
        if (ge < 3) begin
            r   = ge + 1;
            lat = r + 2;
        end
    endtask

    task automatic model_insert(input int s, input int r);
        if (r > 0) begin
            for (int i = 2; i >= r; i--) mb[i] = mb[i-1];
            mb[r-1] = s;
        end
    endtask

    task automatic submit(input int s, input bit poke);
        int r;
        int lat;
        int seen;
        int extra;
        predict(s, r, lat);
        @(negedge clk);
        bus.score_in  = s[7:0];
        bus.game_over = 1'b1;
        @(negedge clk);
        bus.game_over = 1'b0;
        check("busy_rise", {31'd0, bus.busy}, 1);
        seen = 0;
        for (int c = 1; c <= 20 && seen == 0; c++) begin
            @(negedge clk);
            if (poke && c == 1) begin
                bus.score_in  = 8'hFF;
                bus.game_over = 1'b1;
            end
            if (poke && c == 2) bus.game_over = 1'b0;
            if (bus.done === 1'b1) seen = c;
        end
        bus.game_over = 1'b0;
        model_insert(s, r);
        if (seen == 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", seen, lat);
            check("rank", {30'd0, bus.rank}, r);
            check("busy_in_done", {31'd0, bus.busy}, 1);
            check_board("board");
            @(negedge clk);
            check("done_fall", {31'd0, bus.done}, 0);
            check("busy_fall", {31'd0, bus.busy}, 0);
            if (poke) begin
                extra = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (bus.done === 1'b1) extra++;
                end
                check("poke_extra_done", extra, 0);
                check_board("poke_board");
            end
        end
    endtask

    task automatic clear(input bit with_go, input int s);
        int cnt;
        @(negedge clk);
        bus.clear_board = 1'b1;
        bus.game_over   = with_go;
        bus.score_in    = s[7:0];
        @(negedge clk);
        bus.clear_board = 1'b0;
        bus.game_over   = 1'b0;
        mb = '{0, 0, 0};
        check_board("clear");
        check("clear_busy", {31'd0, bus.busy}, 0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        check("clear_no_done", cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        bus.score_in    = 8'd0;
        bus.game_over   = 1'b0;
        bus.clear_board = 1'b0;
        mb = '{0, 0, 0};

        repeat (2) @(negedge clk);
        check_board("reset");
        check("reset_busy", {31'd0, bus.busy}, 0);
        check("reset_done", {31'd0, bus.done}, 0);
        check("reset_rank", {30'd0, bus.rank}, 0);
        rst_n = 1'b1;

        // Directed sequence from the empty board.
        submit(5, 1'b0);
        submit(9, 1'b0);
        submit(7, 1'b0);
        submit(3, 1'b0);
        submit(255, 1'b0);

        // Tie against an existing 7.
        clear(1'b0, 0);
        submit(5, 1'b0);
        submit(9, 1'b0);
        submit(7, 1'b0);
        submit(7, 1'b0);

        // Zero onto an all-zero board is not placed.
        clear(1'b0, 0);
        submit(0, 1'b0);

        // game_over while busy is ignored.
        submit(50, 1'b1);

        // clear_board wins over a simultaneous game_over.
        clear(1'b1, 200);

        // Random traffic with a bias toward small scores so ties occur.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                clear(1'b0, 0);
            end else begin
                if ($urandom_range(0, 1) == 1) s = int'($urandom_range(0, 255));
                else                           s = int'($urandom_range(0, 12));
                submit(s, 1'b0);
            end
        end

        // Async reset while the FSM sits in INSERT.
        clear(1'b0, 0);
        submit(20, 1'b0);
        submit(10, 1'b0);
        @(negedge clk);
        bus.score_in  = 8'd15;
        bus.game_over = 1'b1;
        @(negedge clk);
        bus.game_over = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mb = '{0, 0, 0};
        check_board("midreset");
        check("midreset_busy", {31'd0, bus.busy}, 0);
        check("midreset_rank", {30'd0, bus.rank}, 0);
        check("midreset_done", {31'd0, bus.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        submit(4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_leaderboard_tracker

// File: doc/leaderboard_tracker.md
# leaderboard_tracker

Maintains the top-three high-score table for the reaction game. At the end of each round it takes the final 8-bit score from the scoring stage and inserts it into a sorted three-entry board. The board drives the `lb1`/`lb2`/`lb3` inputs of the scoring/display stage. Insertion runs as a multi-cycle compare-and-shift state machine with a simple start/done handshake.

## Interface
- `SCORE_W`, default 8: width of scores and board entries.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `score_in`  input  SCORE_W  final round score; sampled only with `game_over`.
- `game_over`  input  1  single-cycle request to submit `score_in`.
- `clear_board`  input  1  request to zero all three entries.
- `lb1`, `lb2`, `lb3`  output  SCORE_W each  board entries, registered; `lb1` is the highest.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `done`  output  1  one-cycle pulse when a submission completes.
- `rank`  output  2  placement of the last submission: 1..3, or 0 if not placed. Held until the next `done`.

## Operation
- Reset (async, `reset`=0):
  - `lb1`=`lb2`=`lb3`=0.
  - `rank`=0, `busy`=0, `done`=0.
  - FSM goes to IDLE.
  - Applies immediately, including mid-insertion. No partial shift may survive.
- States: IDLE, CMP, INSERT, DONE.
- IDLE behaviour:
  - If `clear_board`=1: zero all entries. `clear_board` takes priority over a simultaneous `game_over`, which is dropped.
  - Else if `game_over`=1: latch `score_in` into `cand`, set `idx`=0, go to CMP.
- CMP behaviour:
  - If `cand` > entry[`idx`] (unsigned, strict): go to INSERT.
  - Else if `idx`=2: set `rank`=0 and go to DONE.
  - Else: increment `idx` and stay in CMP.
- Ties: an equal score ranks below the existing entry, which is the earlier holder.
- INSERT (single cycle), all updates in the same edge:
  - `idx`=0: `lb3`<=`lb2`, `lb2`<=`lb1`, `lb1`<=`cand`.
  - `idx`=1: `lb3`<=`lb2`, `lb2`<=`cand`.
  - `idx`=2: `lb3`<=`cand`.
  - Set `rank`=`idx`+1, then go to DONE.
- DONE: `done`=1 for this cycle only, then return to IDLE.
- While `busy`=1, `game_over` and `clear_board` are ignored. The requester must wait for `done`; there is no queueing.
- Invariant: `lb1` >= `lb2` >= `lb3` at all times outside INSERT.
- With an all-zero board, a score of 0 is not placed (`rank`=0).

## Timing
- Let edge k be the edge that samples `game_over`=1 in IDLE.
- `busy` rises after edge k.
- Placement at rank r (1..3): `done` is high in the cycle after edge k+r+2, i.e. latency r+2 cycles.
- Not placed: `done` is high after edge k+4 (latency 4 cycles).
- Board outputs change after the INSERT edge, one cycle before `done`.
- `busy` is still high during the `done` cycle and falls with the return to IDLE.
- Earliest accepted back-to-back `game_over` is the cycle after `done`.
- `clear_board` in IDLE: board reads zero after the sampling edge. No `done` pulse.

## Configuration
- `LB_DEDUP_EN` defined:
  - In CMP, if `cand` == entry[`idx`], abort to DONE with `rank`=0.
  - The board is unchanged, so duplicate scores never occupy two slots.
  - Latency in that case is `idx`+3 cycles.
- `LB_DEDUP_EN` undefined: tie handling as in Operation (equal scores placed below).

## Structure
- Package `leaderboard_pkg` holds:
  - state enum `lb_state_t` (IDLE, CMP, INSERT, DONE);
  - `LB_DEPTH`=3;
  - `RANK_NONE`=2'd0;
  - default `SCORE_W`=8.
- Board held as a three-entry array indexed by `idx`.
- No sub-module; the compare and shift are inline.
- Downstream display instances consume `lb1..lb3` directly.

## Test plan
- Reset, empty board; `game_over` with `score_in`=5 -> `rank`=1, board 5/0/0, `done` 3 cycles after the sampling edge.
- Submit 5, 9, 7 in sequence -> ranks 1, 1, 2; final board 9/7/5.
- Board 9/7/5, submit 3 -> `rank`=0, `done` after 4 cycles, board unchanged. Submit 255 -> `rank`=1, board 255/9/7.
- Board 9/7/5, submit 7:
  - without `LB_DEDUP_EN` -> `rank`=3, board 9/7/7;
  - with `LB_DEDUP_EN` -> `rank`=0, board 9/7/5, `done` after 4 cycles.
- Pulse `game_over` while `busy`=1 -> ignored, exactly one `done`. Assert `clear_board` and `game_over` together in IDLE -> board 0/0/0, no `done`.
- Drive `reset` low during INSERT -> board 0/0/0, `busy`=0, `rank`=0 without waiting for an edge. After release, a submission of 4 gives `rank`=1.
